// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing FSM for the 1x3 router ingress path: header decode, payload/parity writes, full stalls.
// Optional feature: define ROUTER_FSM_DROP_EN to add a DROP state and drop_pkt output for invalid addresses.
module router_fsm_ctrl #(
   parameter int                ADDR_W    = 2,
   parameter logic [ADDR_W-1:0] DROP_ADDR = ADDR_W'(3)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pkt_valid,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              fifo_empty_0,
   input  logic              fifo_empty_1,
   input  logic              fifo_empty_2,
   input  logic              soft_reset_0,
   input  logic              soft_reset_1,
   input  logic              soft_reset_2,
   input  logic              parity_done,
   input  logic              low_pkt_valid,
   output logic              detect_add,
   output logic              lfd_state,
   output logic              ld_state,
   output logic              laf_state,
   output logic              full_state,
   output logic              rst_int_reg,
   output logic              write_enb_reg,
`ifdef ROUTER_FSM_DROP_EN
   output logic              drop_pkt,
`endif
   output logic              busy
);

   localparam int NUM_PORTS = 3;

`ifdef ROUTER_FSM_DROP_EN
   localparam int STATE_W = 4;
`else
   localparam int STATE_W = 3;
`endif

   localparam logic [STATE_W-1:0] DA   = STATE_W'(0);
   localparam logic [STATE_W-1:0] LFD  = STATE_W'(1);
   localparam logic [STATE_W-1:0] LD   = STATE_W'(2);
   localparam logic [STATE_W-1:0] FFS  = STATE_W'(3);
   localparam logic [STATE_W-1:0] LAF  = STATE_W'(4);
   localparam logic [STATE_W-1:0] LP   = STATE_W'(5);
   localparam logic [STATE_W-1:0] CPE  = STATE_W'(6);
   localparam logic [STATE_W-1:0] WTE  = STATE_W'(7);
`ifdef ROUTER_FSM_DROP_EN
   localparam logic [STATE_W-1:0] DROP = STATE_W'(8);
`endif

   logic [STATE_W-1:0]   state_reg;
   logic [STATE_W-1:0]   state_next;
   logic [ADDR_W-1:0]    addr_reg;
   logic [NUM_PORTS-1:0] empty_vec;
   logic [NUM_PORTS-1:0] soft_vec;
   logic [NUM_PORTS-1:0] hit_in;
   logic [NUM_PORTS-1:0] hit_q;
   logic                 addr_ok;
   logic                 empty_in;
   logic                 empty_q;
   logic                 abort;

   assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};

   // One-hot port match for the incoming header and the latched address.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign hit_in[gi] = (data_in  == ADDR_W'(gi));
         assign hit_q[gi]  = (addr_reg == ADDR_W'(gi));
      end
   endgenerate

   assign addr_ok  = (data_in != DROP_ADDR) && (|hit_in);
   assign empty_in = |(hit_in & empty_vec);
   assign empty_q  = |(hit_q & empty_vec);
   assign abort    = (state_reg != DA) && (|(hit_q & soft_vec));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         DA: begin
            if (pkt_valid && addr_ok)
               state_next = empty_in ? LFD : WTE;
`ifdef ROUTER_FSM_DROP_EN
            else if (pkt_valid && (data_in == DROP_ADDR))
               state_next = DROP;
`endif
         end
         WTE:  if (empty_q) state_next = LFD;
         LFD:  state_next = LD;
         LD: begin
            if (fifo_full)       state_next = FFS;
            else if (!pkt_valid) state_next = LP;
         end
         FFS:  if (!fifo_full) state_next = LAF;
         LAF: begin
            if (parity_done)        state_next = DA;
            else if (low_pkt_valid) state_next = LP;
            else                    state_next = LD;
         end
         LP:   state_next = CPE;
         CPE:  state_next = fifo_full ? FFS : DA;
`ifdef ROUTER_FSM_DROP_EN
         DROP: if (!pkt_valid) state_next = DA;
`endif
         default: state_next = DA;
      endcase
      // Port soft reset (read timeout) abandons the packet from any active state.
      if (abort) state_next = DA;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= DA;
         addr_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == DA && pkt_valid) addr_reg <= data_in;
      end
   end

`ifdef ROUTER_FSM_DROP_EN
   logic drop_pkt_reg;
   always_ff @(posedge clock) begin
      if (reset) drop_pkt_reg <= 1'b0;
      else       drop_pkt_reg <= (state_reg == DA) && (state_next == DROP);
   end
   assign drop_pkt = drop_pkt_reg;
`endif

   assign detect_add    = (state_reg == DA);
   assign lfd_state     = (state_reg == LFD);
   assign ld_state      = (state_reg == LD);
   assign laf_state     = (state_reg == LAF);
   assign full_state    = (state_reg == FFS);
   assign rst_int_reg   = (state_reg == CPE);
   assign write_enb_reg = (state_reg == LFD) || (state_reg == LD) ||
                          (state_reg == LAF) || (state_reg == LP);
   assign busy          = (state_reg == WTE) || (state_reg == LFD) || (state_reg == FFS) ||
                          (state_reg == LAF) || (state_reg == LP)  || (state_reg == CPE);

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Directed bench for router_fsm_ctrl; define ROUTER_FSM_DROP_EN to exercise the DROP variant.
module tb_router_fsm_ctrl;

   // Output vector order: detect_add, lfd, ld, laf, full, rst_int, write_enb, busy
   localparam logic [7:0] O_DA   = 8'b1000_0000;
   localparam logic [7:0] O_WTE  = 8'b0000_0001;
   localparam logic [7:0] O_LFD  = 8'b0100_0011;
   localparam logic [7:0] O_LD   = 8'b0010_0010;
   localparam logic [7:0] O_FFS  = 8'b0000_1001;
   localparam logic [7:0] O_LAF  = 8'b0001_0011;
   localparam logic [7:0] O_LP   = 8'b0000_0011;
   localparam logic [7:0] O_CPE  = 8'b0000_0101;
   localparam logic [7:0] O_DROP = 8'b0000_0000;

   logic       clock = 1'b0;
   logic       reset, pkt_valid, fifo_full, parity_done, low_pkt_valid;
   logic [1:0] data_in;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       rst_int_reg, write_enb_reg, busy;
`ifdef ROUTER_FSM_DROP_EN
   logic       drop_pkt;
`endif
   logic [7:0] outs;
   int         tests = 0;
   int         fails = 0;

   always #5 clock = ~clock;

   router_fsm_ctrl dut (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
      .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
      .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
      .write_enb_reg(write_enb_reg),
`ifdef ROUTER_FSM_DROP_EN
      .drop_pkt(drop_pkt),
`endif
      .busy(busy)
   );

   assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  rst_int_reg, write_enb_reg, busy};

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL reset_hold: got %b want %b", outs, O_DA); end
      reset = 1'b0;
      tick();
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL reset_release: got %b want %b", outs, O_DA); end
      $display("[TB] reset done");
   endtask

   task automatic test_normal_packet();
      pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
      tick();
      tests++; if (outs !== O_LFD) begin fails++; $display("FAIL norm_lfd: got %b want %b", outs, O_LFD); end
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++; if (outs !== O_LD) begin fails++; $display("FAIL norm_ld%0d: got %b want %b", i, outs, O_LD); end
      end
      pkt_valid = 1'b0;
      tick();
      tests++; if (outs !== O_LP) begin fails++; $display("FAIL norm_lp: got %b want %b", outs, O_LP); end
      tick();
      tests++; if (outs !== O_CPE) begin fails++; $display("FAIL norm_cpe: got %b want %b", outs, O_CPE); end
      tick();
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL norm_da: got %b want %b", outs, O_DA); end
      $display("[TB] normal packet done");
   endtask

   task automatic test_wait_empty();
      pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         tests++; if (outs !== O_WTE) begin fails++; $display("FAIL wte%0d: got %b want %b", i, outs, O_WTE); end
      end
      fifo_empty_1 = 1'b1;
      tick();
      tests++; if (outs !== O_LFD) begin fails++; $display("FAIL wte_lfd: got %b want %b", outs, O_LFD); end
      tick();
      tests++; if (outs !== O_LD) begin fails++; $display("FAIL wte_ld: got %b want %b", outs, O_LD); end
      $display("[TB] wait-for-empty done");
   endtask

   // Entered with the FSM in LD on port 1 and pkt_valid high.
   task automatic test_full_stall();
      fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (outs !== O_FFS) begin fails++; $display("FAIL ffs%0d: got %b want %b", i, outs, O_FFS); end
      end
      fifo_full = 1'b0;
      tick();
      tests++; if (outs !== O_LAF) begin fails++; $display("FAIL laf1: got %b want %b", outs, O_LAF); end
      tick();
      tests++; if (outs !== O_LD) begin fails++; $display("FAIL laf_ld: got %b want %b", outs, O_LD); end
      fifo_full = 1'b1;
      tick();
      tests++; if (outs !== O_FFS) begin fails++; $display("FAIL ffs2: got %b want %b", outs, O_FFS); end
      fifo_full = 1'b0;
      tick();
      tests++; if (outs !== O_LAF) begin fails++; $display("FAIL laf2: got %b want %b", outs, O_LAF); end
      low_pkt_valid = 1'b1;
      tick();
      tests++; if (outs !== O_LP) begin fails++; $display("FAIL laf_lp: got %b want %b", outs, O_LP); end
      low_pkt_valid = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b1;
      tick();
      tests++; if (outs !== O_CPE) begin fails++; $display("FAIL full_cpe: got %b want %b", outs, O_CPE); end
      tick();
      tests++; if (outs !== O_FFS) begin fails++; $display("FAIL cpe_ffs: got %b want %b", outs, O_FFS); end
      fifo_full = 1'b0;
      tick();
      tests++; if (outs !== O_LAF) begin fails++; $display("FAIL laf3: got %b want %b", outs, O_LAF); end
      parity_done = 1'b1;
      tick();
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL laf_da: got %b want %b", outs, O_DA); end
      parity_done = 1'b0;
      $display("[TB] full stall done");
   endtask

   task automatic test_full_priority();
      pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
      tick();
      tick();
      tests++; if (outs !== O_LD) begin fails++; $display("FAIL prio_ld: got %b want %b", outs, O_LD); end
      pkt_valid = 1'b0; fifo_full = 1'b1;
      tick();
      tests++; if (outs !== O_FFS) begin fails++; $display("FAIL prio_ffs: got %b want %b", outs, O_FFS); end
      fifo_full = 1'b0; parity_done = 1'b1;
      tick();
      tick();
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL prio_da: got %b want %b", outs, O_DA); end
      parity_done = 1'b0;
      $display("[TB] full priority done");
   endtask

   task automatic test_soft_reset();
      pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b1;
      tick();
      tick();
      tests++; if (outs !== O_LD) begin fails++; $display("FAIL sr_ld: got %b want %b", outs, O_LD); end
      soft_reset_0 = 1'b1; soft_reset_1 = 1'b1;
      tick();
      tests++; if (outs !== O_LD) begin fails++; $display("FAIL sr_other: got %b want %b", outs, O_LD); end
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b1;
      tick();
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL sr_abort: got %b want %b", outs, O_DA); end
      soft_reset_2 = 1'b0; pkt_valid = 1'b0;
      tick();
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL sr_idle: got %b want %b", outs, O_DA); end
      // Abort from the wait state too.
      pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
      tick();
      tests++; if (outs !== O_WTE) begin fails++; $display("FAIL sr_wte: got %b want %b", outs, O_WTE); end
      pkt_valid = 1'b0; soft_reset_2 = 1'b1;
      tick();
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL sr_wte_abort: got %b want %b", outs, O_DA); end
      soft_reset_2 = 1'b0; fifo_empty_2 = 1'b1;
      $display("[TB] soft reset done");
   endtask

   task automatic test_invalid_addr();
      pkt_valid = 1'b1; data_in = 2'd3;
      tick();
`ifdef ROUTER_FSM_DROP_EN
      tests++; if (outs !== O_DROP) begin fails++; $display("FAIL drop_state: got %b want %b", outs, O_DROP); end
      tests++; if (drop_pkt !== 1'b1) begin fails++; $display("FAIL drop_pulse: got %b want 1", drop_pkt); end
      tick();
      tests++; if (outs !== O_DROP) begin fails++; $display("FAIL drop_hold: got %b want %b", outs, O_DROP); end
      tests++; if (drop_pkt !== 1'b0) begin fails++; $display("FAIL drop_pulse_end: got %b want 0", drop_pkt); end
      pkt_valid = 1'b0;
      tick();
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL drop_da: got %b want %b", outs, O_DA); end
`else
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL inval_da1: got %b want %b", outs, O_DA); end
      tick();
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL inval_da2: got %b want %b", outs, O_DA); end
      pkt_valid = 1'b0;
`endif
      $display("[TB] invalid address done");
   endtask

   task automatic test_reset_override();
      pkt_valid = 1'b1; data_in = 2'd0;
      tick();
      tests++; if (outs !== O_LFD) begin fails++; $display("FAIL ovr_lfd: got %b want %b", outs, O_LFD); end
      pkt_valid = 1'b0; reset = 1'b1; soft_reset_0 = 1'b1;
      tick();
      tests++; if (outs !== O_DA) begin fails++; $display("FAIL ovr_da: got %b want %b", outs, O_DA); end
      reset = 1'b0; soft_reset_0 = 1'b0;
      $display("[TB] reset override done");
   endtask

   initial begin
      reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
      parity_done = 1'b0; low_pkt_valid = 1'b0;
      fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
      test_reset();
      test_normal_packet();
      test_wait_empty();
      test_full_stall();
      test_full_priority();
      test_soft_reset();
      test_invalid_addr();
      test_reset_override();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
